// File: rtl/axim_pkg.sv
// Shared FSM encoding, sizing constants and burst-length helper for the AXI master read controller.
package axim_pkg;

    localparam int MAX_BURST  = 128;
    localparam int FIFO_DEPTH = 512;
    localparam int PAGE_BYTES = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ADDR,
        S_DATA,
        S_NEXT,
        S_DONE
    } rdState_t;

    // Largest legal burst from pageOff: capped by MAX_BURST, the words left and the end of the 4 KB page.
    function automatic logic [8:0] calcBeats(input logic [31:0] remaining, input logic [11:0] pageOff);
        logic [31:0] pageBeats;
        logic [31:0] beats;
        pageBeats = (32'(PAGE_BYTES) - {20'd0, pageOff}) >> 2;
        beats     = 32'(MAX_BURST);
        if (pageBeats < beats) beats = pageBeats;
        if (remaining < beats) beats = remaining;
        return 9'(beats);
    endfunction

endpackage

// File: rtl/axim_rd_ctrlr_sync_fifo.sv
// Single-clock FIFO with a combinational head read, so the head word stays stable while the consumer stalls.
module sync_fifo
    import axim_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk_sys,
    input  logic                     rst_sys,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_pushData,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_headData,
    output logic                     o_notEmpty,
    output logic [$clog2(DEPTH):0]   o_freeCnt
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push && (r_count != DEPTH_CNT);
    assign w_doPop  = i_pop && (r_count != '0);

    always_ff @(posedge clk_sys) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_headData = r_mem[r_rdPtr];
    assign o_notEmpty = (r_count != '0);
    assign o_freeCnt  = DEPTH_CNT - r_count;

endmodule

// File: rtl/axim_rd_ctrlr.sv
// AXI4 master read controller: splits a word-count transfer into 4 KB-safe INCR bursts and streams the data out.
// Optional macro AXIM_RD_RRESP_CHK_EN enables the sticky rd_err flag on non-OKAY read responses.
module axim_rd_ctrlr
    import axim_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk_sys,
    input  logic                      rst_sys,
    input  logic                      kernel_start,
    input  logic [ADDR_WIDTH-1:0]     inbuf_base_addr,
    input  logic [31:0]               inbuf_len,
    output logic                      rd_dn,
    output logic                      rd_idle_sign,
    output logic                      rd_err,
    output logic                      rd_data_vld,
    output logic [DATA_WIDTH-1:0]     rd_axis_data,
    output logic                      rd_data_last,
    output logic [DATA_WIDTH/8-1:0]   rd_data_en,
    input  logic                      rd_data_ready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    rdState_t                     r_state;
    rdState_t                     w_nextState;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic [31:0]                  r_remaining;
    logic [31:0]                  r_total;
    logic [31:0]                  r_popCnt;
    logic [ADDR_WIDTH-1:0]        r_araddr;
    logic [7:0]                   r_arlen;
    logic [8:0]                   r_beats;
    logic [7:0]                   r_beatCnt;
    logic                         r_rdDn;
    logic [8:0]                   w_beats;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_fifoVld;
    logic                         w_isLastWord;
    logic [$clog2(FIFO_DEPTH):0]  w_freeCnt;
    logic                         w_unused;

    assign w_beats      = calcBeats(r_remaining, r_addr[11:0]);
    assign w_push       = m_axi_rready && m_axi_rvalid;
    assign w_pop        = w_fifoVld && rd_data_ready;
    assign w_isLastWord = (r_popCnt + 32'd1 == r_total);
    // Burst end is tracked by beat count alone; rlast is deliberately not trusted.
    assign w_unused     = ^{m_axi_rlast, m_axi_rresp};

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (kernel_start) w_nextState = S_CALC;
            S_CALC: begin
                if (r_remaining == 32'd0)
                    w_nextState = S_NEXT;
                else if ({1'b0, w_beats} <= w_freeCnt)
                    w_nextState = S_ADDR;
            end
            S_ADDR: if (m_axi_arready) w_nextState = S_DATA;
            S_DATA: if (m_axi_rvalid && (r_beatCnt == r_arlen)) w_nextState = S_NEXT;
            S_NEXT: w_nextState = (r_remaining == 32'd0) ? S_DONE : S_CALC;
            S_DONE: if (r_rdDn) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_total     <= '0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_beats     <= '0;
            r_beatCnt   <= '0;
            r_rdDn      <= 1'b0;
        end else begin
            // A zero-length transfer has no last word, so its done pulse comes straight from NEXT.
            r_rdDn <= (w_pop && w_isLastWord) || (r_state == S_NEXT && r_total == 32'd0);
            case (r_state)
                S_IDLE: if (kernel_start) begin
                    r_addr      <= inbuf_base_addr;
                    r_remaining <= inbuf_len;
                    r_total     <= inbuf_len;
                end
                S_CALC: if (w_nextState == S_ADDR) begin
                    r_araddr <= r_addr;
                    r_arlen  <= 8'(w_beats - 9'd1);
                    r_beats  <= w_beats;
                end
                S_ADDR: if (m_axi_arready) begin
                    r_addr      <= r_addr + ADDR_WIDTH'({r_beats, 2'b00});
                    r_remaining <= r_remaining - 32'(r_beats);
                    r_beatCnt   <= '0;
                end
                S_DATA: if (m_axi_rvalid) r_beatCnt <= r_beatCnt + 8'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys)                               r_popCnt <= '0;
        else if (r_state == S_IDLE && kernel_start) r_popCnt <= '0;
        else if (w_pop)                            r_popCnt <= r_popCnt + 32'd1;
    end

`ifdef AXIM_RD_RRESP_CHK_EN
    logic r_rdErr;

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys)                                r_rdErr <= 1'b0;
        else if (r_state == S_IDLE && kernel_start) r_rdErr <= 1'b0;
        else if (w_push && m_axi_rresp != 2'b00)    r_rdErr <= 1'b1;
    end

    assign rd_err = r_rdErr;
`else
    assign rd_err = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys    (clk_sys),
        .rst_sys    (rst_sys),
        .i_push     (w_push),
        .i_pushData (m_axi_rdata),
        .i_pop      (w_pop),
        .o_headData (rd_axis_data),
        .o_notEmpty (w_fifoVld),
        .o_freeCnt  (w_freeCnt)
    );

    assign rd_dn         = r_rdDn;
    assign rd_idle_sign  = (r_state != S_ADDR) && (r_state != S_DATA);
    assign rd_data_vld   = w_fifoVld;
    assign rd_data_last  = w_fifoVld && w_isLastWord;
    assign rd_data_en    = '1;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'd2;
    assign m_axi_arburst = 2'd1;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd3;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_arvalid = (r_state == S_ADDR);
    assign m_axi_rready  = (r_state == S_DATA);

endmodule
